// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: datapath format, arctangent table, gain constant
// and the sequencer state encoding used by the vectoring and cosine units.
package cordic_pkg;

    localparam int unsigned WIDTH  = 22;
    localparam int unsigned FRAC   = 20;
    localparam int unsigned N_ITER = 16;
    localparam int unsigned LUT_W  = 4;

    // 1/An for 16 micro-rotations, Q2.20
    localparam logic [WIDTH-1:0] K_GAIN = 22'h09B74E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SCALE = 2'd2
    } cordic_state_t;

    // atan(2^-k) in Q2.20 radians
    function automatic logic [WIDTH-1:0] atan_lut(input logic [LUT_W-1:0] k);
        logic [WIDTH-1:0] e;
        e = '0;
        case (k)
            4'd0:  e = 22'h0C90FD;
            4'd1:  e = 22'h076B19;
            4'd2:  e = 22'h03EB6E;
            4'd3:  e = 22'h01FD5B;
            4'd4:  e = 22'h00FFAA;
            4'd5:  e = 22'h007FF5;
            4'd6:  e = 22'h003FFE;
            4'd7:  e = 22'h001FFF;
            4'd8:  e = 22'h000FFF;
            4'd9:  e = 22'h0007FF;
            4'd10: e = 22'h0003FF;
            4'd11: e = 22'h0001FF;
            4'd12: e = 22'h0000FF;
            4'd13: e = 22'h00007F;
            4'd14: e = 22'h00003F;
            4'd15: e = 22'h00001F;
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: steers y towards zero and
// accumulates the applied angle in z.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = cordic_pkg::WIDTH,
    parameter int unsigned K_W   = 4
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] z,
    input  logic        [K_W-1:0]   k,
    input  logic signed [WIDTH-1:0] e_k,
    output logic signed [WIDTH-1:0] x_nxt,
    output logic signed [WIDTH-1:0] y_nxt,
    output logic signed [WIDTH-1:0] z_nxt
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;

    assign x_sh = x >>> k;
    assign y_sh = y >>> k;

    // Rotate against the sign of y; all sums wrap at WIDTH bits
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        z_nxt = z;
        if (y[WIDTH-1]) begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - e_k;
        end else begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + e_k;
        end
    end

endmodule

// File: rtl/cordic_vectoring_atan_mag.sv
// Vectoring-mode CORDIC: returns atan(y/x) and the gain-compensated |(x,y)|,
// running ITER_PER_CYCLE chained micro-rotations per clock.
module cordic_vectoring_atan_mag #(
    parameter int unsigned WIDTH          = cordic_pkg::WIDTH,
    parameter int unsigned N_ITER         = cordic_pkg::N_ITER,
    parameter int unsigned ITER_PER_CYCLE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic signed [WIDTH-1:0] angle_out,
    output logic signed [WIDTH-1:0] mag_out,
    output logic                    busy,
    output logic                    done,
    output logic                    range_err
);

    import cordic_pkg::*;

    localparam int unsigned I_W = $clog2(N_ITER + 1);
    localparam int unsigned K_W = $clog2(N_ITER);
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic signed [WIDTH-1:0] V_LIM   = WIDTH'(32'h0008_0000);
    localparam logic signed [WIDTH-1:0] V_LIM_N = -V_LIM;
    localparam logic signed [WIDTH-1:0] K_S     = WIDTH'(K_GAIN);

    cordic_state_t           state_q, state_d;
    logic [I_W-1:0]          i_q, i_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic                    bad_q, bad_d;
    logic                    zero_q, zero_d;
    logic signed [WIDTH-1:0] angle_d;
    logic signed [WIDTH-1:0] mag_d;
    logic                    busy_d;
    logic                    done_d;
    logic                    range_err_d;

    logic                    legal_c;
    logic                    zero_c;
    logic signed [PW-1:0]    prod_c;
    logic signed [WIDTH-1:0] mag_c;

    // Domain keeps the gain-grown x below 2.0 so Q2.20 never overflows
    assign legal_c = !x_in[WIDTH-1] && (x_in < V_LIM) &&
                     (y_in < V_LIM) && (y_in > V_LIM_N);
    assign zero_c  = (x_in == '0) && (y_in == '0);

    assign prod_c = PW'(x_q) * PW'(K_S);
    assign mag_c  = WIDTH'(prod_c >>> FRAC);

    logic signed [WIDTH-1:0] cx [ITER_PER_CYCLE+1];
    logic signed [WIDTH-1:0] cy [ITER_PER_CYCLE+1];
    logic signed [WIDTH-1:0] cz [ITER_PER_CYCLE+1];

    assign cx[0] = x_q;
    assign cy[0] = y_q;
    assign cz[0] = z_q;

    for (genvar s = 0; s < ITER_PER_CYCLE; s++) begin : g_stage
        logic [K_W-1:0]          k_s;
        logic signed [WIDTH-1:0] e_s;

        assign k_s = K_W'(i_q) + K_W'(s);
        assign e_s = WIDTH'(atan_lut(LUT_W'(k_s)));

        cordic_vec_stage #(
            .WIDTH (WIDTH),
            .K_W   (K_W)
        ) u_stage (
            .x     (cx[s]),
            .y     (cy[s]),
            .z     (cz[s]),
            .k     (k_s),
            .e_k   (e_s),
            .x_nxt (cx[s+1]),
            .y_nxt (cy[s+1]),
            .z_nxt (cz[s+1])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            bad_q     <= 1'b0;
            zero_q    <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            bad_q     <= bad_d;
            zero_q    <= zero_d;
            angle_out <= angle_d;
            mag_out   <= mag_d;
            busy      <= busy_d;
            done      <= done_d;
            range_err <= range_err_d;
        end
    end

    // Sequencer: capture, iterate, then scale and publish
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        bad_d       = bad_q;
        zero_d      = zero_q;
        angle_d     = angle_out;
        mag_d       = mag_out;
        busy_d      = busy;
        done_d      = 1'b0;
        range_err_d = range_err;

        unique case (state_q)
            ST_IDLE: begin
                if (clk_en) begin
                    state_d = ST_ITER;
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = '0;
                    i_d     = '0;
                    bad_d   = !legal_c;
                    zero_d  = zero_c;
                    busy_d  = 1'b1;
                end
            end
            ST_ITER: begin
                x_d = cx[ITER_PER_CYCLE];
                y_d = cy[ITER_PER_CYCLE];
                z_d = cz[ITER_PER_CYCLE];
                i_d = i_q + I_W'(ITER_PER_CYCLE);
                if ((i_q + I_W'(ITER_PER_CYCLE)) == I_W'(N_ITER)) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                range_err_d = bad_q;
                // A null vector has no direction; report angle 0
                angle_d     = (bad_q || zero_q) ? '0 : z_q;
                mag_d       = bad_q ? '0 : mag_c;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cordic_vectoring_atan_mag.sv
// Directed bench for the vectoring CORDIC: table of vectors with hand-computed
// angle/magnitude, plus sequencing and mid-job reset scenarios.
module tb_cordic_vectoring_atan_mag;

    localparam int unsigned W   = 22;
    localparam int          TOL = 64;
    localparam int          LAT = 5;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] ang;
        logic [W-1:0] mag;
        logic         rerr;
        int           tol;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clk_en = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] angle_out;
    logic [W-1:0] mag_out;
    logic         busy;
    logic         done;
    logic         range_err;

    int n_chk = 0;
    int n_pass = 0;

    cordic_vectoring_atan_mag dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        n_chk++;
        if (d <= tol && d >= -tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
    endtask

    // Called at a negedge; returns posedges after start until done, or -1
    task automatic wait_done(input int budget, output int cyc, inout int bc);
        cyc = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic job(input logic [W-1:0] x, input logic [W-1:0] y,
                       output int cyc, output int bc);
        x_in   = x;
        y_in   = y;
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        bc = busy ? 1 : 0;
        wait_done(20, cyc, bc);
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bc, nd;

        vt[0]  = '{x: 22'h040000, y: 22'h000000, ang: 22'h000000, mag: 22'h040000, rerr: 1'b0, tol: TOL};
        vt[1]  = '{x: 22'h040000, y: 22'h040000, ang: 22'h0C90FD, mag: 22'h05A827, rerr: 1'b0, tol: TOL};
        vt[2]  = '{x: 22'h040000, y: 22'h3C0000, ang: 22'h336F03, mag: 22'h05A827, rerr: 1'b0, tol: TOL};
        vt[3]  = '{x: 22'h000000, y: 22'h040000, ang: 22'h1921FB, mag: 22'h040000, rerr: 1'b0, tol: TOL};
        vt[4]  = '{x: 22'h3F0000, y: 22'h000000, ang: 22'h000000, mag: 22'h000000, rerr: 1'b1, tol: 0};
        vt[5]  = '{x: 22'h040000, y: 22'h020000, ang: 22'h076B1B, mag: 22'h0478DD, rerr: 1'b0, tol: TOL};
        vt[6]  = '{x: 22'h000000, y: 22'h000000, ang: 22'h000000, mag: 22'h000000, rerr: 1'b0, tol: 0};
        vt[7]  = '{x: 22'h07FFFF, y: 22'h07FFFF, ang: 22'h0C90FD, mag: 22'h0B504D, rerr: 1'b0, tol: TOL};
        vt[8]  = '{x: 22'h080000, y: 22'h000000, ang: 22'h000000, mag: 22'h000000, rerr: 1'b1, tol: 0};
        vt[9]  = '{x: 22'h040000, y: 22'h080000, ang: 22'h000000, mag: 22'h000000, rerr: 1'b1, tol: 0};
        vt[10] = '{x: 22'h040000, y: 22'h380000, ang: 22'h000000, mag: 22'h000000, rerr: 1'b1, tol: 0};
        vt[11] = '{x: 22'h07FFFF, y: 22'h380001, ang: 22'h336F03, mag: 22'h0B504D, rerr: 1'b0, tol: TOL};

        repeat (2) @(negedge clk);
        chk("rst_angle", sx(angle_out), 0, 0);
        chk("rst_mag",   sx(mag_out),   0, 0);
        chk("rst_busy",  int'(busy),    0, 0);
        chk("rst_done",  int'(done),    0, 0);
        chk("rst_rerr",  int'(range_err), 0, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            job(vt[v].x, vt[v].y, cyc, bc);
            chk($sformatf("v%0d_latency", v), cyc, LAT, 0);
            chk($sformatf("v%0d_busy_cycles", v), bc, LAT, 0);
            chk($sformatf("v%0d_range_err", v), int'(range_err), int'(vt[v].rerr), 0);
            chk($sformatf("v%0d_angle", v), sx(angle_out), sx(vt[v].ang), vt[v].tol);
            chk($sformatf("v%0d_mag", v), sx(mag_out), sx(vt[v].mag), vt[v].tol);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", v), int'(done), 0, 0);
            chk($sformatf("v%0d_rerr_hold", v), int'(range_err), int'(vt[v].rerr), 0);
        end

        // clk_en held through ITER with other operands: ignored, not queued
        x_in   = 22'h040000;
        y_in   = 22'h040000;
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_in = 22'h07FFFF;
        y_in = 22'h000000;
        cyc  = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) clk_en = 1'b0;
            if (done) begin
                cyc = n;
                break;
            end
        end
        chk("busy_ign_latency", cyc, LAT, 0);
        chk("busy_ign_angle", sx(angle_out), sx(22'h0C90FD), TOL);
        chk("busy_ign_mag", sx(mag_out), sx(22'h05A827), TOL);
        count_dones(12, nd);
        chk("busy_ign_no_extra_done", nd, 0, 0);

        // Start accepted in the done cycle
        job(22'h040000, 22'h000000, cyc, bc);
        chk("b2b_first_latency", cyc, LAT, 0);
        job(22'h000000, 22'h040000, cyc, bc);
        chk("b2b_second_latency", cyc, LAT, 0);
        chk("b2b_second_busy", bc, LAT, 0);
        chk("b2b_second_angle", sx(angle_out), sx(22'h1921FB), TOL);
        chk("b2b_second_mag", sx(mag_out), sx(22'h040000), TOL);

        // Reset during ITER aborts and clears outputs at once
        @(negedge clk);
        x_in   = 22'h040000;
        y_in   = 22'h040000;
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_angle", sx(angle_out), 0, 0);
        chk("mid_rst_mag",   sx(mag_out),   0, 0);
        chk("mid_rst_busy",  int'(busy),    0, 0);
        chk("mid_rst_done",  int'(done),    0, 0);
        @(negedge clk);
        reset = 1'b1;
        count_dones(12, nd);
        chk("mid_rst_no_done", nd, 0, 0);

        job(22'h040000, 22'h040000, cyc, bc);
        chk("post_rst_latency", cyc, LAT, 0);
        chk("post_rst_angle", sx(angle_out), sx(22'h0C90FD), TOL);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
